// File: rtl/lenet_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lenet_frame_sequencer
//   Frame-level controller in front of the two-set LeNet core. It hands the
//   two input image banks back and forth between the host loader and the
//   core, launches the core with conv_start, and follows the core through
//   conv_done -> fc1_done -> fc2_done. Each of those three waits is guarded
//   by a watchdog. It reports frame completion, a frame count and sticky
//   error flags.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   enable            level; allows a new frame to launch from IDLE
//   host_load_done    pulse; host finished writing bank host_bank
//   host_load_ready   bank host_bank is free for the host
//   host_bank         bank the host must write next
//   mem_sel           bank the core reads
//   conv_start        one-cycle start pulse to the core
//   conv_done, fc1_done, fc2_done   stage completion pulses from the core
//   frame_done        one-cycle pulse for each completed frame
//   frame_count       completed frames, modulo 2^FCNT_W
//   busy              controller is not IDLE
//   clear_err         pulse; clears error flags and leaves ERROR
//   err_timeout, err_order, err_overrun   sticky error flags
// ---------------------------------------------------------------------------
module lenet_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned TO_W           = 20,
    parameter int unsigned FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              host_load_done,
    output logic              host_load_ready,
    output logic              host_bank,
    output logic              mem_sel,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic              fc1_done,
    input  logic              fc2_done,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count,
    output logic              busy,
    input  logic              clear_err,
    output logic              err_timeout,
    output logic              err_order,
    output logic              err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CONV, S_FC1, S_FC2, S_DONE, S_ERROR
    } state_t;

    // Watchdog value on the last allowed cycle of a stage.
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nx;
    logic [1:0]        bank_full, bank_full_nx;
    logic              host_bank_nx;
    logic              core_bank, core_bank_nx;
    logic [TO_W-1:0]   wd, wd_nx;
    logic [FCNT_W-1:0] fcnt_nx;
    logic              err_to_nx, err_ord_nx, err_ovr_nx;
    logic [2:0]        done_vec, exp_vec;
    logic              exp_hit, stray;

    assign host_load_ready = ~bank_full[host_bank];
    assign mem_sel         = core_bank;
    assign busy            = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bank_full   <= '0;
            host_bank   <= 1'b0;
            core_bank   <= 1'b0;
            wd          <= '0;
            frame_count <= '0;
            err_timeout <= 1'b0;
            err_order   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nx;
            bank_full   <= bank_full_nx;
            host_bank   <= host_bank_nx;
            core_bank   <= core_bank_nx;
            wd          <= wd_nx;
            frame_count <= fcnt_nx;
            err_timeout <= err_to_nx;
            err_order   <= err_ord_nx;
            err_overrun <= err_ovr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bank_full_nx = bank_full;
        host_bank_nx = host_bank;
        core_bank_nx = core_bank;
        wd_nx        = wd;
        fcnt_nx      = frame_count;
        err_to_nx    = err_timeout;
        err_ord_nx   = err_order;
        err_ovr_nx   = err_overrun;
        conv_start   = 1'b0;
        frame_done   = 1'b0;

        // Only the wait states expect a done; everywhere else any done is
        // stray. An expected done together with a stray one counts as stray.
        done_vec = {fc2_done, fc1_done, conv_done};
        case (state)
            S_CONV:  exp_vec = 3'b001;
            S_FC1:   exp_vec = 3'b010;
            S_FC2:   exp_vec = 3'b100;
            default: exp_vec = 3'b000;
        endcase
        exp_hit = |(done_vec & exp_vec);
        stray   = |(done_vec & ~exp_vec);

        // Clear first so that an error raised in the same cycle survives.
        if (clear_err) begin
            err_to_nx  = 1'b0;
            err_ord_nx = 1'b0;
            err_ovr_nx = 1'b0;
        end

        // Host side works off registered bank state. The core only ever
        // frees a full bank and the host only fills an empty one, so both
        // updates can land in the same cycle without colliding.
        if (host_load_done) begin
            if (!bank_full[host_bank]) begin
                bank_full_nx[host_bank] = 1'b1;
                host_bank_nx            = ~host_bank;
            end else begin
                err_ovr_nx = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (stray) err_ord_nx = 1'b1;
                if (enable && bank_full[core_bank]) state_nx = S_START;
            end
            S_START: begin
                conv_start = 1'b1;
                wd_nx      = '0;
                if (stray) err_ord_nx = 1'b1;
                state_nx   = S_CONV;
            end
            S_CONV, S_FC1, S_FC2: begin
                if (stray) begin
                    err_ord_nx = 1'b1;
                    state_nx   = S_ERROR;
                end else if (exp_hit) begin
                    // An expected done beats a watchdog expiring this cycle.
                    wd_nx    = '0;
                    state_nx = (state == S_CONV) ? S_FC1 :
                               (state == S_FC1)  ? S_FC2 : S_DONE;
                end else if (wd == WD_LAST) begin
                    err_to_nx = 1'b1;
                    state_nx  = S_ERROR;
                end else begin
                    wd_nx = wd + TO_W'(1);
                end
            end
            S_DONE: begin
                frame_done              = 1'b1;
                if (stray) err_ord_nx   = 1'b1;
                bank_full_nx[core_bank] = 1'b0;
                core_bank_nx            = ~core_bank;
                fcnt_nx                 = frame_count + FCNT_W'(1);
                state_nx                = S_IDLE;
            end
            S_ERROR: begin
                // The frame in flight is dropped: release its bank without
                // counting it.
                if (clear_err) begin
                    bank_full_nx[core_bank] = 1'b0;
                    core_bank_nx            = ~core_bank;
                    state_nx                = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lenet_frame_sequencer
//   Directed bench for lenet_frame_sequencer. A frame-level model tracks how
//   many banks are loaded, how many loads and frames have gone through, and
//   which core stage is pending. From those it derives every output, and the
//   outputs are compared each cycle. Hand-computed cycle and value checks pin
//   the headline timing.
//   Cycle numbering: cycle 0 starts at reset release. An input driven in
//   cycle c is sampled at the edge that ends cycle c.
// ---------------------------------------------------------------------------
module tb_lenet_frame_sequencer;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned TO_W    = 5;
    localparam int unsigned FCNT_W  = 2;

    localparam logic [4:0] P_HLD = 5'b00001;
    localparam logic [4:0] P_CD  = 5'b00010;
    localparam logic [4:0] P_F1  = 5'b00100;
    localparam logic [4:0] P_F2  = 5'b01000;
    localparam logic [4:0] P_CLR = 5'b10000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              host_load_done = 1'b0;
    logic              conv_done = 1'b0;
    logic              fc1_done = 1'b0;
    logic              fc2_done = 1'b0;
    logic              clear_err = 1'b0;
    logic              host_load_ready, host_bank, mem_sel, conv_start;
    logic              frame_done, busy, err_timeout, err_order, err_overrun;
    logic [FCNT_W-1:0] frame_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Frame-level model state.
    int m_stage;   // 0 idle, 1 start, 2 conv wait, 3 fc1 wait, 4 fc2 wait, 5 done, 6 error
    int m_loaded;  // banks holding an image not yet retired
    int m_wr;      // accepted host loads
    int m_rd;      // frames retired (completed or dropped)
    int m_wait;    // cycles already spent in the current wait stage
    int m_frames;  // completed frames
    bit m_eto, m_eord, m_eovr;

    always #5 clk = ~clk;

    lenet_frame_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W          (TO_W),
        .FCNT_W        (FCNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .host_load_done (host_load_done),
        .host_load_ready(host_load_ready),
        .host_bank      (host_bank),
        .mem_sel        (mem_sel),
        .conv_start     (conv_start),
        .conv_done      (conv_done),
        .fc1_done       (fc1_done),
        .fc2_done       (fc2_done),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .busy           (busy),
        .clear_err      (clear_err),
        .err_timeout    (err_timeout),
        .err_order      (err_order),
        .err_overrun    (err_overrun)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_loaded = 0; m_wr = 0; m_rd = 0;
        m_wait = 0; m_frames = 0;
        m_eto = 1'b0; m_eord = 1'b0; m_eovr = 1'b0;
    endtask

    task automatic model_step();
        bit d[3];
        bit hit, stray;
        int had;
        d[0] = conv_done; d[1] = fc1_done; d[2] = fc2_done;
        had = m_loaded;
        hit = 1'b0; stray = 1'b0;
        for (int k = 0; k < 3; k++)
            if (d[k]) begin
                if (m_stage >= 2 && m_stage <= 4 && k == m_stage - 2) hit = 1'b1;
                else stray = 1'b1;
            end
        if (clear_err) begin
            m_eto = 1'b0; m_eord = 1'b0; m_eovr = 1'b0;
        end
        if (host_load_done) begin
            if (had < 2) begin m_loaded++; m_wr++; end
            else m_eovr = 1'b1;
        end
        case (m_stage)
            0: begin
                if (stray) m_eord = 1'b1;
                if (enable && had > 0) m_stage = 1;
            end
            1: begin
                if (stray) m_eord = 1'b1;
                m_stage = 2; m_wait = 0;
            end
            2, 3, 4: begin
                if (stray) begin m_eord = 1'b1; m_stage = 6; end
                else if (hit) begin m_stage++; m_wait = 0; end
                else if (m_wait + 1 >= int'(TIMEOUT)) begin m_eto = 1'b1; m_stage = 6; end
                else m_wait++;
            end
            5: begin
                if (stray) m_eord = 1'b1;
                m_loaded--; m_rd++; m_frames++; m_stage = 0;
            end
            default: begin
                if (clear_err) begin m_loaded--; m_rd++; m_stage = 0; end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("host_load_ready", int'(host_load_ready), int'(m_loaded < 2));
        chk("host_bank",       int'(host_bank),       m_wr % 2);
        chk("mem_sel",         int'(mem_sel),         m_rd % 2);
        chk("conv_start",      int'(conv_start),      int'(m_stage == 1));
        chk("frame_done",      int'(frame_done),      int'(m_stage == 5));
        chk("busy",            int'(busy),            int'(m_stage != 0));
        chk("frame_count",     int'(frame_count),     m_frames % (1 << FCNT_W));
        chk("err_timeout",     int'(err_timeout),     int'(m_eto));
        chk("err_order",       int'(err_order),       int'(m_eord));
        chk("err_overrun",     int'(err_overrun),     int'(m_eovr));
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, and
    // return just after the edge so the caller can drive the next cycle.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!rst) model_step();
        cyc++;
        #1;
    endtask

    task automatic step(input logic [4:0] p);
        host_load_done = p[0];
        conv_done      = p[1];
        fc1_done       = p[2];
        fc2_done       = p[3];
        clear_err      = p[4];
        tick();
        {clear_err, fc2_done, fc1_done, conv_done, host_load_done} = 5'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {clear_err, fc2_done, fc1_done, conv_done, host_load_done} = 5'b0;
        model_reset();
        #1;
        idle(2);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL tb_time_limit cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        #1;

        // 1: single frame, nominal timing; the fc1/fc2 dones arrive on the
        //    last cycle the watchdog allows, and the done wins.
        enable = 1'b1;
        do_reset();
        chk("t1_reset_ready", int'(host_load_ready), 1);
        chk("t1_reset_busy", int'(busy), 0);
        wait_until(5);
        step(P_HLD);
        chk("t1_host_bank_c6", int'(host_bank), 1);
        chk("t1_ready_c6", int'(host_load_ready), 1);
        chk("t1_no_start_c6", int'(conv_start), 0);
        wait_until(7);
        chk("t1_conv_start_c7", int'(conv_start), 1);
        chk("t1_mem_sel_c7", int'(mem_sel), 0);
        wait_until(20); step(P_CD);
        wait_until(40); step(P_F1);
        wait_until(60); step(P_F2);
        chk("t1_frame_done_c61", int'(frame_done), 1);
        chk("t1_no_error_c61", int'(err_timeout), 0);
        idle(1);
        chk("t1_frame_count", int'(frame_count), 1);
        chk("t1_mem_sel_after", int'(mem_sel), 1);

        // 2: both banks loaded, third load overruns; back-to-back frames.
        do_reset();
        wait_until(2);
        step(P_HLD); step(P_HLD);
        chk("t2_ready_full_c4", int'(host_load_ready), 0);
        chk("t2_conv_start_c4", int'(conv_start), 1);
        step(P_HLD);
        chk("t2_overrun", int'(err_overrun), 1);
        chk("t2_host_bank", int'(host_bank), 0);
        wait_until(10); step(P_CD);
        wait_until(12); step(P_F1);
        wait_until(14); step(P_F2);
        chk("t2_frame_done_c15", int'(frame_done), 1);
        idle(1);
        chk("t2_gap_c16", int'(conv_start), 0);
        idle(1);
        chk("t2_conv_start_c17", int'(conv_start), 1);
        chk("t2_mem_sel_c17", int'(mem_sel), 1);
        wait_until(20); step(P_CD);
        wait_until(22); step(P_F1);
        wait_until(24); step(P_F2);
        idle(1);
        chk("t2_frame_count", int'(frame_count), 2);

        // 3: watchdog expiry in CONV, then clear_err drops the frame.
        do_reset();
        wait_until(1); step(P_HLD);
        wait_until(23);
        chk("t3_no_timeout_c23", int'(err_timeout), 0);
        idle(1);
        chk("t3_timeout_c24", int'(err_timeout), 1);
        chk("t3_busy_err", int'(busy), 1);
        wait_until(30); step(P_CLR);
        chk("t3_cleared", int'(err_timeout), 0);
        chk("t3_idle", int'(busy), 0);
        chk("t3_bank_moved", int'(mem_sel), 1);
        chk("t3_count_kept", int'(frame_count), 0);
        idle(3);

        // 4: stray done in IDLE, clear outside ERROR, wrong done in CONV.
        enable = 1'b0;
        do_reset();
        wait_until(1); step(P_CD);
        chk("t4_order_idle", int'(err_order), 1);
        chk("t4_idle_stays", int'(busy), 0);
        step(P_CLR);
        chk("t4_clear_idle", int'(err_order), 0);
        enable = 1'b1;
        wait_until(5); step(P_HLD);
        wait_until(10); step(P_F1);
        chk("t4_order_conv", int'(err_order), 1);
        idle(4);
        chk("t4_busy_held", int'(busy), 1);
        step(P_CLR);
        idle(2);

        // 5: asynchronous reset in FC1, then launch gated by enable.
        enable = 1'b1;
        do_reset();
        wait_until(1); step(P_HLD);
        wait_until(6); step(P_CD);
        wait_until(9);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_host_bank", int'(host_bank), 0);
        chk("t5_async_ready", int'(host_load_ready), 1);
        chk("t5_async_frame_done", int'(frame_done), 0);
        enable = 1'b0;
        do_reset();
        wait_until(2); step(P_HLD);
        wait_until(10);
        chk("t5_gated_busy", int'(busy), 0);
        enable = 1'b1;
        idle(1);
        chk("t5_start_c11", int'(conv_start), 1);
        idle(2);

        // 6: five quick frames, frame_count wraps at 2^FCNT_W.
        do_reset();
        for (int f = 0; f < 5; f++) begin
            int exp_cnt;
            exp_cnt = (f + 1) % 4;
            step(P_HLD);
            idle(2);
            step(P_CD);
            step(P_F1);
            step(P_F2);
            idle(1);
            chk("t6_frame_count", int'(frame_count), exp_cnt);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
